mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//   Initiator-side load/store sequencer between the CPU datapath and the word-wide DM port.
//   Accepts one LW/LB/SW/SB/SWRR request at a time over a valid/ready handshake.
//   Drives DM word accesses; SB uses a read-modify-write sequence on the word.
//   Returns sign-extended/rotated results and error status as a one-cycle response pulse.
// PARAMETERS
//   ADDR_W  32  byte-address width of req_addr / mem_addr
//   RD_LAT  1   DM read latency in cycles, mem_re -> mem_rdata valid; legal 1..4
// PORTS
//   clk        in   1       rising-edge clock, only clock domain
//   reset      in   1       asynchronous, active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       block can accept a request (high only in IDLE)
//   req_op     in   3       000 LW, 001 LB, 010 SW, 011 SB, 100 SWRR, others illegal
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   32      store data
//   req_pc     in   32      PC of issuing instruction, forwarded to DM for write trace
//   rsp_valid  out  1       one-cycle completion pulse
//   rsp_rdata  out  32      load result, 0 for stores/errors
//   rsp_err    out  1       qualifies rsp_valid: misaligned LW/SW or illegal op
//   mem_addr   out  ADDR_W  word-aligned DM address, bits [1:0] always 0
//   mem_re     out  1       one-cycle DM read strobe
//   mem_we     out  1       one-cycle DM write strobe, full word
//   mem_wdata  out  32      DM write data
//   mem_pc     out  32      latched req_pc, stable throughout access
//   mem_rdata  in   32      DM read data, sampled RD_LAT cycles after mem_re
// BEHAVIOUR
//   Reset (async, reset==0)
//     state=IDLE; req_ready=1; all other outputs 0.
//     mem_we drops immediately, so no partial write occurs; in-flight op is discarded.
//   FSM: IDLE -> RD -> WAIT -> {WR} -> RESP -> IDLE; all outputs are registered.
//   IDLE
//     Handshake completes when req_valid && req_ready; op/addr/wdata/pc are latched.
//     LW/LB/SB -> RD. SW/SWRR -> WR.
//     LW or SW with addr[1:0]!=0, or an illegal op -> RESP with err=1; no DM access.
//   RD: mem_re=1 for exactly one cycle, mem_addr={addr[ADDR_W-1:2],2'b00}.
//   WAIT
//     Counts RD_LAT cycles, then captures mem_rdata.
//     LW/LB -> RESP. SB -> WR.
//   WR: mem_we=1 for exactly one cycle; mem_wdata is selected by op:
//     SW:   wdata.
//     SB:   captured word with byte lane off=addr[1:0] replaced by wdata[7:0].
//     SWRR: wdata rotated right by 8*off bits; all offsets are legal.
//   RESP: rsp_valid=1 for one cycle, with rsp_rdata and rsp_err; -> IDLE.
//     req_ready stays 0 here, so back-to-back requests are spaced by at least 1 IDLE cycle.
//   Load results
//     LB: {{24{b[7]}},b}, where b=word[8*off+7:8*off].
//     LW: word.
//   Latency (T = accept cycle)
//     SW/SWRR: WR at T+1, RESP at T+2.
//     LW/LB:   RD at T+1, RESP at T+2+RD_LAT.
//     SB:      RD at T+1, WR at T+2+RD_LAT, RESP at T+3+RD_LAT.
//     Error:   RESP at T+1.
//   Invariants
//     mem_re and mem_we are never high together.
//     rsp_rdata and rsp_err are held 0 when rsp_valid=0.
//     req_* inputs are ignored outside IDLE.
// TESTING (RD_LAT=1, DM model preloaded)
//   SW addr=0x10 wdata=0xFABC1234 -> mem_we at T+1, addr 0x10, data 0xFABC1234; rsp ok at T+2.
//   SWRR addr=0x13 wdata=0xFABC1234 -> mem_addr=0x10, mem_wdata=0xBC1234FA; rsp err=0.
//   SB addr=0x11 wdata=0xAA, DM[0x10]=0x11223344
//     -> RD then WR of 0x1122AA44; rsp at T+4.
//   LB addr=0x12, DM[0x10]=0x0080FF00 -> rsp_rdata=0xFFFFFF80 at T+3.
//   LB addr=0x11 on same word -> 0xFFFFFFFF.
//   LW addr=0x02 -> rsp_err=1 at T+1, no mem_re/mem_we.
//   req_op=111 -> rsp_err=1, no DM access.
//   Assert reset low during SB WAIT
//     -> outputs 0 immediately, no mem_we, DM word unchanged.
//     After release, req_ready=1 and a new LW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU datapath and a word-wide DM port; SB done as read-modify-write.
// Latency: SW/SWRR 2, LW/LB 2+RD_LAT, SB 3+RD_LAT, errors 1 cycle; one request in flight, req_ready only in IDLE.
module mem_access_ctrl #(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [31:0]       req_pc,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [31:0]       mem_wdata,
   output logic [31:0]       mem_pc,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RESP} state_t;

   localparam logic [2:0] OP_LW   = 3'b000;
   localparam logic [2:0] OP_LB   = 3'b001;
   localparam logic [2:0] OP_SW   = 3'b010;
   localparam logic [2:0] OP_SB   = 3'b011;
   localparam logic [2:0] OP_SWRR = 3'b100;
   localparam logic [1:0] LAT_M1  = 2'(RD_LAT - 1);

   state_t              state_q;
   logic [2:0]          op_q;
   logic [1:0]          off_q;
   logic [7:0]          byte_q;
   logic [1:0]          cnt_q;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic [31:0]         rsp_rdata_q;
   logic                rsp_err_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                mem_re_q;
   logic                mem_we_q;
   logic [31:0]         mem_wdata_q;
   logic [31:0]         mem_pc_q;

   logic                req_bad_d;
   logic [4:0]          req_sh_d;
   logic [31:0]         swrr_d;
   logic [7:0]          rd_byte_d;
   logic [31:0]         lb_d;
   logic [31:0]         sb_word_d;

   assign req_bad_d = (req_op > OP_SWRR) ||
                      (((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00));
   assign req_sh_d  = {req_addr[1:0], 3'b000};
   // Shifting a 32-bit value by 32 yields 0, so offset 0 degenerates to a plain copy.
   assign swrr_d    = (req_wdata >> req_sh_d) | (req_wdata << (6'd32 - {1'b0, req_sh_d}));
   assign rd_byte_d = mem_rdata[{off_q, 3'b000} +: 8];
   assign lb_d      = {{24{rd_byte_d[7]}}, rd_byte_d};

   always_comb begin
      sb_word_d = mem_rdata;
      sb_word_d[{off_q, 3'b000} +: 8] = byte_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         off_q       <= '0;
         byte_q      <= '0;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         mem_pc_q    <= '0;
      end else begin
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  op_q        <= req_op;
                  off_q       <= req_addr[1:0];
                  byte_q      <= req_wdata[7:0];
                  mem_pc_q    <= req_pc;
                  req_ready_q <= 1'b0;
                  if (req_bad_d) begin
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     state_q     <= S_RESP;
                  end else begin
                     mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                     if (req_op == OP_SW || req_op == OP_SWRR) begin
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= (req_op == OP_SW) ? req_wdata : swrr_d;
                        state_q     <= S_WR;
                     end else begin
                        mem_re_q <= 1'b1;
                        state_q  <= S_RD;
                     end
                  end
               end
            end
            S_RD: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == LAT_M1) begin
                  if (op_q == OP_SB) begin
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= sb_word_d;
                     state_q     <= S_WR;
                  end else begin
                     rsp_valid_q <= 1'b1;
                     rsp_rdata_q <= (op_q == OP_LB) ? lb_d : mem_rdata;
                     state_q     <= S_RESP;
                  end
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            S_WR: begin
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               req_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               req_ready_q <= 1'b1;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_pc    = mem_pc_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed table-driven bench for mem_access_ctrl with RD_LAT=1 and a behavioural word-wide DM.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_pc;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.ADDR_W(32), .RD_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_pc(mem_pc), .mem_rdata(mem_rdata)
   );

   // DM model: one-cycle read latency, full-word writes
   logic [31:0] dm [0:15];
   int          we_total = 0;
   logic        both_hi = 1'b0;
   logic        idle_bad = 1'b0;

   always @(posedge clk) begin
      if (mem_re) mem_rdata <= dm[mem_addr[5:2]];
      if (mem_we) begin
         dm[mem_addr[5:2]] <= mem_wdata;
         we_total = we_total + 1;
      end
      if (mem_re && mem_we) both_hi = 1'b1;
   end

   always @(negedge clk) begin
      if (!rsp_valid && (rsp_rdata != 32'h0 || rsp_err)) idle_bad = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          re;
      int          we;
      logic [31:0] waddr;
      logic [31:0] wdat;
   } vec_t;

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic err, input int lat,
                               input int re, input int we, input logic [31:0] waddr,
                               input logic [31:0] wdat);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
      v.lat = lat; v.re = re; v.we = we; v.waddr = waddr; v.wdat = wdat;
      return v;
   endfunction

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk({name, "_ready_timeout"}, 32'(req_ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string       nm;
      int          n;
      int          re_n;
      int          we_n;
      logic        got;
      logic [31:0] ra, wa, wd, wpc, pc;
      nm = $sformatf("v%0d", idx);
      pc = 32'h1000 + 32'(idx * 4);
      wait_ready(nm);
      req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata; req_pc = pc;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_op = 3'b000; req_addr = '0; req_wdata = '0; req_pc = '0;
      n = 1; got = 1'b0; re_n = 0; we_n = 0;
      ra = '0; wa = '0; wd = '0; wpc = '0;
      while (!got && n <= 20) begin
         if (mem_re) begin re_n++; ra = mem_addr; end
         if (mem_we) begin we_n++; wa = mem_addr; wd = mem_wdata; wpc = mem_pc; end
         if (rsp_valid) begin
            got = 1'b1;
            chk({nm, "_lat"}, 32'(n), 32'(v.lat));
            chk({nm, "_rdata"}, rsp_rdata, v.rdata);
            chk({nm, "_err"}, 32'(rsp_err), 32'(v.err));
            chk({nm, "_ready_in_resp"}, 32'(req_ready), 32'd0);
         end else begin
            @(posedge clk);
            #1;
            n++;
         end
      end
      if (!got) chk({nm, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
      chk({nm, "_re_count"}, 32'(re_n), 32'(v.re));
      chk({nm, "_we_count"}, 32'(we_n), 32'(v.we));
      if (v.re != 0) chk({nm, "_rd_addr"}, ra, {v.addr[31:2], 2'b00});
      if (v.we != 0) begin
         chk({nm, "_wr_addr"}, wa, v.waddr);
         chk({nm, "_wr_data"}, wd, v.wdat);
         chk({nm, "_wr_pc"}, wpc, pc);
      end
   endtask

   localparam logic [2:0] LW = 3'b000, LB = 3'b001, SW = 3'b010, SB = 3'b011, SWRR = 3'b100;

   vec_t vecs [22];
   int   we_before;

   initial begin
      vecs[0]  = mk(SW,     32'h10, 32'hFABC1234, 32'h0,        1'b0, 2, 0, 1, 32'h10, 32'hFABC1234);
      vecs[1]  = mk(LW,     32'h10, 32'h0,        32'hFABC1234, 1'b0, 3, 1, 0, 32'h0,  32'h0);
      vecs[2]  = mk(SWRR,   32'h13, 32'hFABC1234, 32'h0,        1'b0, 2, 0, 1, 32'h10, 32'hBC1234FA);
      vecs[3]  = mk(LW,     32'h10, 32'h0,        32'hBC1234FA, 1'b0, 3, 1, 0, 32'h0,  32'h0);
      vecs[4]  = mk(SW,     32'h10, 32'h11223344, 32'h0,        1'b0, 2, 0, 1, 32'h10, 32'h11223344);
      vecs[5]  = mk(SB,     32'h11, 32'h000000AA, 32'h0,        1'b0, 4, 1, 1, 32'h10, 32'h1122AA44);
      vecs[6]  = mk(LW,     32'h10, 32'h0,        32'h1122AA44, 1'b0, 3, 1, 0, 32'h0,  32'h0);
      vecs[7]  = mk(SW,     32'h10, 32'h0080FF00, 32'h0,        1'b0, 2, 0, 1, 32'h10, 32'h0080FF00);
      vecs[8]  = mk(LB,     32'h12, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 0, 32'h0,  32'h0);
      vecs[9]  = mk(LB,     32'h11, 32'h0,        32'hFFFFFFFF, 1'b0, 3, 1, 0, 32'h0,  32'h0);
      vecs[10] = mk(LB,     32'h10, 32'h0,        32'h00000000, 1'b0, 3, 1, 0, 32'h0,  32'h0);
      vecs[11] = mk(LB,     32'h13, 32'h0,        32'h00000000, 1'b0, 3, 1, 0, 32'h0,  32'h0);
      vecs[12] = mk(SWRR,   32'h20, 32'h12345678, 32'h0,        1'b0, 2, 0, 1, 32'h20, 32'h12345678);
      vecs[13] = mk(SWRR,   32'h21, 32'h12345678, 32'h0,        1'b0, 2, 0, 1, 32'h20, 32'h78123456);
      vecs[14] = mk(LW,     32'h20, 32'h0,        32'h78123456, 1'b0, 3, 1, 0, 32'h0,  32'h0);
      vecs[15] = mk(SB,     32'h23, 32'hFFFFFF7E, 32'h0,        1'b0, 4, 1, 1, 32'h20, 32'h7E123456);
      vecs[16] = mk(LB,     32'h23, 32'h0,        32'h0000007E, 1'b0, 3, 1, 0, 32'h0,  32'h0);
      vecs[17] = mk(LW,     32'h02, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,  32'h0);
      vecs[18] = mk(SW,     32'h05, 32'h55555555, 32'h0,        1'b1, 1, 0, 0, 32'h0,  32'h0);
      vecs[19] = mk(3'b111, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,  32'h0);
      vecs[20] = mk(3'b101, 32'h20, 32'h0,        32'h0,        1'b1, 1, 0, 0, 32'h0,  32'h0);
      vecs[21] = mk(LW,     32'h14, 32'h0,        32'hCAFEF00D, 1'b0, 3, 1, 0, 32'h0,  32'h0);

      for (int i = 0; i < 16; i++) dm[i] = 32'h0;
      dm[5]  = 32'hCAFEF00D;
      dm[12] = 32'hDEADBEEF;

      reset = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mem_re",    32'(mem_re),    32'd0);
      chk("rst_mem_we",    32'(mem_we),    32'd0);
      chk("rst_mem_addr",  mem_addr,       32'd0);
      chk("rst_mem_wdata", mem_wdata,      32'd0);
      chk("rst_mem_pc",    mem_pc,         32'd0);
      chk("rst_rsp_rdata", rsp_rdata,      32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 22; i++) run_vec(vecs[i], i);

      // Reset asserted while an SB sits in WAIT must abort it with no write
      wait_ready("rstsb");
      we_before = we_total;
      req_valid = 1'b1; req_op = SB; req_addr = 32'h31; req_wdata = 32'h55; req_pc = 32'h2000;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("rstsb_rd_strobe", 32'(mem_re), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("rstsb_mem_we",    32'(mem_we),    32'd0);
      chk("rstsb_mem_re",    32'(mem_re),    32'd0);
      chk("rstsb_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstsb_req_ready", 32'(req_ready), 32'd1);
      chk("rstsb_mem_addr",  mem_addr,       32'd0);
      chk("rstsb_mem_pc",    mem_pc,         32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      chk("rstsb_no_write", 32'(we_total - we_before), 32'd0);
      chk("rstsb_dm_word",  dm[12], 32'hDEADBEEF);
      run_vec(mk(LW, 32'h30, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1, 0, 32'h0, 32'h0), 99);

      chk("re_we_exclusive", 32'(both_hi),  32'd0);
      chk("rsp_zero_idle",   32'(idle_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
